// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the control sequencer and its opcode queue.
package ctrl_seq_pkg;

    localparam int OP_W       = 7;   // opcode / decoder input width
    localparam int CTRL_W     = 26;  // decoder output / control word width
    localparam int CONST1_BIT = 23;  // decoder output that must always read 1
    localparam int EXLEN_LSB  = 5;   // opcode field giving execute length - 1
    localparam int EXLEN_W    = 2;
    localparam int CNT_W      = 2;   // covers DEC_LAT-1 (<=3) and exec length (<=3)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ISSUE  = 2'd2,
        EXEC   = 2'd3
    } state_t;

    // Number of EXEC cycles minus one encoded in the opcode.
    function automatic logic [EXLEN_W-1:0] exec_len(input logic [OP_W-1:0] op);
        return op[EXLEN_LSB +: EXLEN_W];
    endfunction

endpackage

// File: rtl/ctrl_seq_fifo.sv
// Synchronous opcode queue: power-of-two depth, wrapping pointers, full/empty flags.
module ctrl_seq_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Next pointer/count values; a push is refused while full even if a pop is in flight.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage.
    // NOTE: storage is deliberately not reset; the empty flag guards every read of stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Opcode sequencer around the external control decoder: queue, decode wait,
// valid/ready issue of the sampled control word, then an opcode-length execute hold-off.
module ctrl_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int DEC_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [OP_W-1:0]   op_i,
    output logic [OP_W-1:0]   dec_pi_o,
    input  logic [CTRL_W-1:0] dec_po_i,
    output logic              ctrl_valid_o,
    input  logic              ctrl_ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              err_o
);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   dec_pi_q, dec_pi_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [OP_W-1:0]   fifo_head;
    logic              fifo_full, fifo_empty, fifo_pop;

    ctrl_seq_fifo #(
        .W     (OP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (op_valid_i),
        .data_i  (op_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign op_ready_o   = !fifo_full;
    assign dec_pi_o     = dec_pi_q;
    assign ctrl_o       = ctrl_q;
    assign err_o        = err_q;
    assign ctrl_valid_o = (state_q == ISSUE);
    assign done_o       = (state_q == EXEC) && (cnt_q == '0);
    assign busy_o       = (state_q != IDLE) || !fifo_empty;

    // Sequencer next-state logic. The active opcode is dec_pi_q itself: it is loaded
    // on pop and held for the whole operation, so no separate opcode copy is needed.
    always_comb begin
        state_d  = state_q;
        dec_pi_d = dec_pi_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    dec_pi_d = fifo_head;
                    cnt_d    = CNT_W'(DEC_LAT - 1);
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ctrl_d = dec_po_i;
                    // A missing constant-one bit flags a broken decoder but does not stop issue.
                    if (!dec_po_i[CONST1_BIT]) err_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ctrl_ready_i) begin
                    cnt_d   = CNT_W'(exec_len(dec_pi_q));
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, decoder drive, control word and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dec_pi_q <= '0;
            ctrl_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dec_pi_q <= dec_pi_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with a stand-in decoder model and an issue scoreboard.
module tb_ctrl_sequencer;

    logic        clk;
    logic        rst_n;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [6:0]  op_i;
    logic [6:0]  dec_pi_o;
    logic [25:0] dec_po_i;
    logic        ctrl_valid_o;
    logic        ctrl_ready_i;
    logic [25:0] ctrl_o;
    logic        done_o;
    logic        busy_o;
    logic        err_o;

    int          vectors = 0;
    int          miscompares = 0;
    int          done_count = 0;
    int          issue_count = 0;
    logic        force_err = 1'b0;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_ctrl = '0;
    logic [25:0] sb_q[$];

    // Stand-in for the combinational decoder: bit 23 is the constant-one output.
    function automatic logic [25:0] dec_model(input logic [6:0] op);
        logic [25:0] w;
        w[6:0]   = op;
        w[13:7]  = ~op;
        w[20:14] = op ^ 7'h2A;
        w[22:21] = op[1:0] ^ op[6:5];
        w[23]    = 1'b1;
        w[25:24] = op[3:2] | op[5:4];
        return w;
    endfunction

    assign dec_po_i = force_err ? (dec_model(dec_pi_o) & 26'h37FFFFF) : dec_model(dec_pi_o);

    ctrl_sequencer #(
        .FIFO_DEPTH (2),
        .DEC_LAT    (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid_i   (op_valid_i),
        .op_ready_o   (op_ready_o),
        .op_i         (op_i),
        .dec_pi_o     (dec_pi_o),
        .dec_po_i     (dec_po_i),
        .ctrl_valid_o (ctrl_valid_o),
        .ctrl_ready_i (ctrl_ready_i),
        .ctrl_o       (ctrl_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [6:0] op, input logic [25:0] exp);
        int n = 0;
        while (!op_ready_o && n < 200) begin
            step();
            n++;
        end
        chk("push_ready", op_ready_o, 1);
        op_valid_i = 1'b1;
        op_i       = op;
        sb_q.push_back(exp);
        step();
        op_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ctrl_valid_o && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, ctrl_valid_o, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy_o || sb_q.size() != 0) && n < 500) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, busy_o, 0);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_op_ready"}, op_ready_o, 1);
        chk({tag, "_dec_pi"}, dec_pi_o, 0);
        chk({tag, "_ctrl"}, ctrl_o, 0);
        chk({tag, "_valid"}, ctrl_valid_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    // Issue monitor: scoreboard pop on each handshake, stall stability, done pulse count.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (done_o) done_count++;
            if (prev_stall) chk("ctrl_hold", ctrl_o, prev_ctrl);
            if (ctrl_valid_o && ctrl_ready_i) begin
                issue_count++;
                if (sb_q.size() == 0) chk("issue_expected", 0, 1);
                else                  chk("issue_word", ctrl_o, sb_q.pop_front());
            end
            prev_stall = ctrl_valid_o && !ctrl_ready_i;
            prev_ctrl  = ctrl_o;
        end
    end

    initial begin
        int done_before;
        int issue_before;
        logic pushes_done;

        rst_n        = 1'b0;
        op_valid_i   = 1'b0;
        op_i         = '0;
        ctrl_ready_i = 1'b0;
        repeat (2) step();
        chk_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Single op 05, datapath always ready.
        ctrl_ready_i = 1'b1;
        push_op(7'h05, dec_model(7'h05));
        chk("single_busy_idle", busy_o, 1);
        chk("single_valid_idle", ctrl_valid_o, 0);
        step();
        chk("single_dec_pi", dec_pi_o, 7'h05);
        chk("single_valid_decode", ctrl_valid_o, 0);
        step();
        chk("single_valid", ctrl_valid_o, 1);
        chk("single_ctrl", ctrl_o, dec_model(7'h05));
        step();
        chk("single_done", done_o, 1);
        chk("single_busy_exec", busy_o, 1);
        step();
        chk("single_done_low", done_o, 0);
        chk("single_busy_low", busy_o, 0);

        // Long op 60: done only in the fourth cycle after the handshake.
        ctrl_ready_i = 1'b0;
        push_op(7'h60, dec_model(7'h60));
        wait_valid("long");
        ctrl_ready_i = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            chk($sformatf("long_done_h%0d", k), done_o, (k == 4) ? 1 : 0);
            step();
        end
        wait_idle("long");

        // Backpressure with a full queue behind the active op.
        ctrl_ready_i = 1'b0;
        push_op(7'h01, dec_model(7'h01));
        push_op(7'h02, dec_model(7'h02));
        push_op(7'h03, dec_model(7'h03));
        chk("bp_op_ready_full", op_ready_o, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), ctrl_valid_o, 1);
            chk($sformatf("bp_ctrl_%0d", k), ctrl_o, dec_model(7'h01));
            chk($sformatf("bp_full_%0d", k), op_ready_o, 0);
            step();
        end
        ctrl_ready_i = 1'b1;
        wait_idle("bp");
        chk("bp_ctrl_hold_last", ctrl_o, dec_model(7'h03));
        chk("bp_dec_pi_hold_last", dec_pi_o, 7'h03);

        // Error path: constant-one bit missing when the word is sampled.
        chk("err_before", err_o, 0);
        force_err = 1'b1;
        push_op(7'h0A, dec_model(7'h0A) & 26'h37FFFFF);
        chk("err_idle", err_o, 0);
        wait_valid("err");
        chk("err_set", err_o, 1);
        chk("err_word_bit23", ctrl_o[23], 0);
        force_err = 1'b0;
        wait_idle("err");
        push_op(7'h21, dec_model(7'h21));
        wait_idle("err_next");
        chk("err_sticky", err_o, 1);

        // Reset in the middle of EXEC with two opcodes queued.
        ctrl_ready_i = 1'b0;
        push_op(7'h60, dec_model(7'h60));
        push_op(7'h01, dec_model(7'h01));
        push_op(7'h02, dec_model(7'h02));
        wait_valid("rst");
        ctrl_ready_i = 1'b1;
        step();
        ctrl_ready_i = 1'b0;
        step();
        chk("rst_pre_done", done_o, 0);
        chk("rst_pre_full", op_ready_o, 0);
        done_before = done_count;
        rst_n = 1'b0;
        #1;
        chk_reset_values("rst_mid");
        sb_q.delete();
        repeat (4) step();
        chk("rst_no_done", done_count, done_before);
        rst_n = 1'b1;
        step();
        issue_before = issue_count;
        ctrl_ready_i = 1'b1;
        push_op(7'h11, dec_model(7'h11));
        wait_idle("rst_after");
        chk("rst_after_issues", issue_count - issue_before, 1);
        chk("rst_after_ctrl", ctrl_o, dec_model(7'h11));

        // Ten back-to-back random ops with random datapath stalls.
        done_before  = done_count;
        issue_before = issue_count;
        pushes_done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [6:0] op;
                    op = 7'($urandom_range(0, 127));
                    push_op(op, dec_model(op));
                end
                pushes_done = 1'b1;
            end
            begin
                for (int c = 0; c < 2000; c++) begin
                    step();
                    if (pushes_done && sb_q.size() == 0 && !busy_o) break;
                    ctrl_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        ctrl_ready_i = 1'b1;
        wait_idle("wrap");
        chk("wrap_done_pulses", done_count - done_before, 10);
        chk("wrap_issues", issue_count - issue_before, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
